// File: rtl/sr_cmd_sequencer_if.sv
// Button inputs and latch command outputs of the SR command sequencer.
// master drives the raw buttons; slave is the sequencer itself.
interface sr_cmd_sequencer_if;
  logic       btn_set;
  logic       btn_rst;
  logic       s;
  logic       r;
  logic       e;
  logic       busy;
  logic [1:0] state_dbg;

  modport master (
    output btn_set, btn_rst,
    input  s, r, e, busy, state_dbg
  );

  modport slave (
    input  btn_set, btn_rst,
    output s, r, e, busy, state_dbg
  );
endinterface

// File: rtl/sr_cmd_sequencer.sv
// Debounces two raw buttons and turns each press into one s/r/e frame for a gated SR latch.
// Optional macro SR_CMD_RESET_PRIORITY_EN: a frame carrying both set and reset issues s=0, r=1.
module sr_cmd_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 2,
  parameter int CNT_W           = 16
) (
  input logic               clk,
  input logic               rst,
  sr_cmd_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // The sync1 sample is the first stable cycle, so DEBOUNCE_CYCLES-1 mismatches at sync2 accept a level.
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);

  // Bit 0 is the set button, bit 1 the reset button throughout.
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            deb_dly_q, deb_dly_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            pend_q, pend_d;
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      pcnt_q, pcnt_d;
  logic                  s_q, s_d;
  logic                  r_q, r_d;
  logic                  e_q, e_d;
  logic [1:0]            req;
  logic [1:0]            want;

  always_comb begin
    sync1_d   = {bus.btn_rst, bus.btn_set};
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    cnt_d     = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign req  = deb_q & ~deb_dly_q;
  assign want = pend_q | req;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    s_d     = s_q;
    r_d     = r_q;
    e_d     = e_q;
    pend_d  = pend_q | req;
    case (state_q)
      ST_IDLE: begin
        s_d = 1'b0;
        r_d = 1'b0;
        e_d = 1'b0;
        if (want != 2'b00) begin
          state_d = ST_SETUP;
          pend_d  = 2'b00;
`ifdef SR_CMD_RESET_PRIORITY_EN
          s_d     = want[0] & ~want[1];
`else
          s_d     = want[0];
`endif
          r_d     = want[1];
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        pcnt_d  = '0;
        e_d     = 1'b1;
      end
      ST_STROBE: begin
        if (pcnt_q == PULSE_LAST) begin
          state_d = ST_HOLD;
          e_d     = 1'b0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
        e_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      cnt_q     <= '0;
      pend_q    <= '0;
      state_q   <= ST_IDLE;
      pcnt_q    <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      e_q       <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      s_q       <= s_d;
      r_q       <= r_d;
      e_q       <= e_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.e         = e_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.state_dbg = state_q;

endmodule
